mem_beat_responder: RTL and testbench

//  Memory-side responder for the 256-bit ip_ram port driven by the data aligner (rden/wren/ip_address/byteena/writeData).

---
 rtl/mem_beat_responder_pkg.sv | 31 +++
 rtl/mem_beat_responder_rd_assembler.sv | 58 +++++
 rtl/mem_beat_responder.sv | 165 ++++++++++++++++
 tb/tb_mem_beat_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_beat_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_beat_responder_pkg
//   Shared types and constants for the 256-bit to 32-bit beat responder.
//   - state_t : responder FSM states (IDLE, WRITE, READ, DONE)
//   - beat_t  : 3-bit beat index within one 256-bit block
//   - BEATS   : number of narrow RAM words per upstream block
// ---------------------------------------------------------------------------
package mem_beat_responder_pkg;

  localparam int V_DEF  = 256;
  localparam int W_DEF  = 32;
  localparam int AW_DEF = 14;
  localparam int BEATS  = V_DEF / W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [2:0] beat_t;

  localparam beat_t LAST_BEAT = beat_t'(BEATS - 1);

  // True on the final beat of a block; the counter wraps to 0 right after it.
  function automatic logic isLastBeat(input beat_t b);
    return (b == LAST_BEAT);
  endfunction

endpackage

// File: rtl/mem_beat_responder_rd_assembler.sv
// ---------------------------------------------------------------------------
// rd_assembler
//   Collects the 32-bit words returned by the RAM and packs them into the
//   256-bit readData register. A valid pipeline RD_LAT deep tracks each
//   read strobe so the returned word is captured exactly when it arrives.
//   Ports:
//     clk          : clock, rising edge
//     rst          : asynchronous active-low reset
//     i_ramRe      : RAM read strobe issued this cycle
//     i_ramRdata   : RAM read data (valid RD_LAT cycles after i_ramRe)
//     o_readData   : assembled block, beat b in bits [W*b +: W]
//     o_lastWord   : the final word of the block is being captured this cycle
// ---------------------------------------------------------------------------
module rd_assembler
  import mem_beat_responder_pkg::*;
#(
  parameter int V      = 256,
  parameter int W      = 32,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ramRe,
  input  logic [W-1:0] i_ramRdata,
  output logic [V-1:0] o_readData,
  output logic         o_lastWord
);

  logic [RD_LAT-1:0] r_vld;
  beat_t             r_idx;
  logic [V-1:0]      r_readData;
  logic              w_capture;

  assign w_capture  = r_vld[RD_LAT-1];
  assign o_lastWord = w_capture && isLastBeat(r_idx);
  assign o_readData = r_readData;

  // The valid pipeline mirrors the RAM's read latency. Words return in issue
  // order, so a simple wrapping index is enough to place each one; it lands
  // back on 0 after the eighth word, ready for the next block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld      <= '0;
      r_idx      <= '0;
      r_readData <= '0;
    end else begin
      r_vld[0] <= i_ramRe;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
      if (w_capture) begin
        r_readData[int'(r_idx)*W +: W] <= i_ramRdata;
        r_idx                          <= r_idx + beat_t'(1);
      end
    end
  end

endmodule

// File: rtl/mem_beat_responder.sv
// ---------------------------------------------------------------------------
// mem_beat_responder
//   Memory-side responder for the aligner's 256-bit RAM port. Every block
//   access is served as eight sequential 32-bit beats on a narrow word RAM;
//   read beats are reassembled into readData. busy stalls the aligner while
//   an access is in flight.
//   Ports:
//     clk, rst             : clock (rising edge), async active-low reset
//     rden, wren           : upstream read / write request
//     ip_address           : block address (AW bits)
//     byteena, writeData   : upstream byte enables and write data
//     readData             : assembled read block (held across writes/idle)
//     resp_valid           : one-cycle completion pulse
//     busy                 : access outstanding, upstream must hold
//     ram_addr             : word address {block, beat}
//     ram_re, ram_we       : RAM read / write strobes
//     ram_be, ram_wdata    : per-beat byte enables and write data
//     ram_rdata            : RAM read data, RD_LAT cycles after ram_re
//   RD_LAT is legal in the range 1..2.
// ---------------------------------------------------------------------------
module mem_beat_responder
  import mem_beat_responder_pkg::*;
#(
  parameter int V      = 256,
  parameter int W      = 32,
  parameter int AW     = 14,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rden,
  input  logic           wren,
  input  logic [AW-1:0]  ip_address,
  input  logic [V/8-1:0] byteena,
  input  logic [V-1:0]   writeData,
  output logic [V-1:0]   readData,
  output logic           resp_valid,
  output logic           busy,
  output logic [AW+2:0]  ram_addr,
  output logic           ram_re,
  output logic           ram_we,
  output logic [W/8-1:0] ram_be,
  output logic [W-1:0]   ram_wdata,
  input  logic [W-1:0]   ram_rdata
);

  state_t           r_state;
  beat_t            r_beat;
  logic             r_issued;
  logic [AW-1:0]    r_addr;
  logic [V/8-1:0]   r_be;
  logic [V-1:0]     r_wdata;

  logic [W/8-1:0]   w_beatBe;
  logic [W-1:0]     w_beatData;
  logic             w_lastWord;

  assign w_beatBe   = r_be[int'(r_beat)*(W/8) +: W/8];
  assign w_beatData = r_wdata[int'(r_beat)*W +: W];

  // Responder FSM. Writes win over a simultaneous read; the read is not
  // captured and upstream presents it again. In READ the issue side stops
  // once all eight strobes are out (r_issued), while completion waits for
  // the assembler to capture the last returned word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_beat   <= '0;
      r_issued <= 1'b0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (wren) begin
            r_addr  <= ip_address;
            r_be    <= byteena;
            r_wdata <= writeData;
            r_state <= WRITE;
          end else if (rden) begin
            r_addr   <= ip_address;
            r_issued <= 1'b0;
            r_state  <= READ;
          end
        end
        WRITE: begin
          r_beat <= r_beat + beat_t'(1);
          if (isLastBeat(r_beat)) begin
            r_state <= DONE;
          end
        end
        READ: begin
          if (!r_issued) begin
            r_beat <= r_beat + beat_t'(1);
            if (isLastBeat(r_beat)) begin
              r_issued <= 1'b1;
            end
          end
          if (w_lastWord) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // RAM side is decoded from state and captured registers. In IDLE busy
  // follows the request inputs so the requesting cycle already stalls the
  // aligner; DONE drops busy so upstream can move on the next cycle. Beats
  // whose byte enables are all zero still spend their cycle, just without
  // a write strobe.
  always_comb begin
    busy      = 1'b0;
    ram_addr  = '0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_wdata = '0;
    case (r_state)
      IDLE: begin
        busy = rden | wren;
      end
      WRITE: begin
        busy      = 1'b1;
        ram_addr  = {r_addr, r_beat};
        ram_be    = w_beatBe;
        ram_wdata = w_beatData;
        ram_we    = |w_beatBe;
      end
      READ: begin
        busy = 1'b1;
        if (!r_issued) begin
          ram_re   = 1'b1;
          ram_addr = {r_addr, r_beat};
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign resp_valid = (r_state == DONE);

  rd_assembler #(
    .V      (V),
    .W      (W),
    .RD_LAT (RD_LAT)
  ) u_rdAssembler (
    .clk        (clk),
    .rst        (rst),
    .i_ramRe    (ram_re),
    .i_ramRdata (ram_rdata),
    .o_readData (readData),
    .o_lastWord (w_lastWord)
  );

endmodule

// File: tb/tb_mem_beat_responder.sv
// Bench for mem_beat_responder: a word RAM model with configurable read
// latency, directed requests, and a negedge monitor that pops expected RAM
// beats and responses from scoreboard queues.
module tb_mem_beat_responder;

  localparam int TB_RD_LAT = 1;
  localparam int MEM_WORDS = 131072;

  logic         clk = 1'b0;
  logic         rst;
  logic         rden;
  logic         wren;
  logic [13:0]  ipAddress;
  logic [31:0]  byteena;
  logic [255:0] writeData;
  logic [255:0] readData;
  logic         respValid;
  logic         busy;
  logic [16:0]  ramAddr;
  logic         ramRe;
  logic         ramWe;
  logic [3:0]   ramBe;
  logic [31:0]  ramWdata;
  logic [31:0]  ramRdata;

  always #5 clk = ~clk;

  mem_beat_responder #(
    .V      (256),
    .W      (32),
    .AW     (14),
    .RD_LAT (TB_RD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rden       (rden),
    .wren       (wren),
    .ip_address (ipAddress),
    .byteena    (byteena),
    .writeData  (writeData),
    .readData   (readData),
    .resp_valid (respValid),
    .busy       (busy),
    .ram_addr   (ramAddr),
    .ram_re     (ramRe),
    .ram_we     (ramWe),
    .ram_be     (ramBe),
    .ram_wdata  (ramWdata),
    .ram_rdata  (ramRdata)
  );

  // Word RAM model: byte-enabled writes, read data after TB_RD_LAT cycles.
  // memInit loads words 0..7 with A000_0000+k and clears the rest once.
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] rdPipe [TB_RD_LAT];
  logic        memInit;

  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= (i < 8) ? (32'hA000_0000 + 32'(i)) : 32'h0;
      end
    end else if (ramWe) begin
      for (int b = 0; b < 4; b++) begin
        if (ramBe[b]) mem[ramAddr][8*b +: 8] <= ramWdata[8*b +: 8];
      end
    end
    rdPipe[0] <= mem[ramAddr];
    for (int i = 1; i < TB_RD_LAT; i++) begin
      rdPipe[i] <= rdPipe[i-1];
    end
  end

  assign ramRdata = rdPipe[TB_RD_LAT-1];

  typedef struct {
    logic [16:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wrBeat_t;

  typedef struct {
    logic [255:0] data;
    int           cycle;
  } resp_t;

  wrBeat_t      expWr[$];
  logic [16:0]  expRd[$];
  resp_t        expResp[$];
  wrBeat_t      monWr;
  logic [16:0]  monRd;
  resp_t        monResp;

  int           cyc = 0;
  int           checks = 0;
  int           passes = 0;
  logic [255:0] lastRead;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Monitor: every strobe or response the DUT presents must match the head
  // of the matching scoreboard queue; anything unexpected is a failure.
  always @(negedge clk) begin
    if (rst) begin
      if (ramWe) begin
        if (expWr.size() == 0) checkOutput("unexpectedRamWe", 1, 0);
        else begin
          monWr = expWr.pop_front();
          checkOutput("ramWeAddr", ramAddr, monWr.addr);
          checkOutput("ramWeBe", ramBe, monWr.be);
          checkOutput("ramWeData", ramWdata, monWr.data);
        end
      end
      if (ramRe) begin
        if (expRd.size() == 0) checkOutput("unexpectedRamRe", 1, 0);
        else begin
          monRd = expRd.pop_front();
          checkOutput("ramReAddr", ramAddr, monRd);
        end
      end
      if (respValid) begin
        if (expResp.size() == 0) checkOutput("unexpectedResp", 1, 0);
        else begin
          monResp = expResp.pop_front();
          checkOutput("respReadData", readData, monResp.data);
          checkOutput("respCycle", 256'(cyc), 256'(monResp.cycle));
        end
      end
    end
  end

  // Drives one request in IDLE (called #1 after a rising edge) and pushes
  // the hand-derived expectations for it.
  task automatic applyStimulus(input logic w, input logic r, input logic [13:0] a,
                               input logic [31:0] be, input logic [255:0] wd,
                               input logic [255:0] expData, input string tag);
    resp_t   rsp;
    wrBeat_t wb;
    int      c0;
    wren = w; rden = r; ipAddress = a; byteena = be; writeData = wd;
    c0 = cyc;
    if (w) begin
      for (int b = 0; b < 8; b++) begin
        if (|be[4*b +: 4]) begin
          wb.addr = {a, 3'(b)};
          wb.be   = be[4*b +: 4];
          wb.data = wd[32*b +: 32];
          expWr.push_back(wb);
        end
      end
      rsp.data = lastRead; rsp.cycle = c0 + 9;
      expResp.push_back(rsp);
    end else if (r) begin
      for (int b = 0; b < 8; b++) expRd.push_back({a, 3'(b)});
      rsp.data = expData; rsp.cycle = c0 + 9 + TB_RD_LAT;
      expResp.push_back(rsp);
      lastRead = expData;
    end
    #1;
    checkOutput({tag, "_busyReqCycle"}, busy, 1);
  endtask

  // Waits (bounded) for resp_valid, checking busy stays high until then and
  // drops in the response cycle; returns in the cycle after resp_valid.
  task automatic waitResp(input string tag);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (respValid) seen = 1'b1;
      else checkOutput({tag, "_busyInFlight"}, busy, 1);
    end
    if (!seen) checkOutput({tag, "_respTimeout"}, 0, 1);
    else checkOutput({tag, "_busyInDone"}, busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic idleInputs();
    wren = 1'b0; rden = 1'b0; ipAddress = '0; byteena = '0; writeData = '0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_readData"}, readData, 0);
    checkOutput({tag, "_respValid"}, respValid, 0);
    checkOutput({tag, "_ramRe"}, ramRe, 0);
    checkOutput({tag, "_ramWe"}, ramWe, 0);
    checkOutput({tag, "_ramAddr"}, ramAddr, 0);
    checkOutput({tag, "_ramBe"}, ramBe, 0);
    checkOutput({tag, "_ramWdata"}, ramWdata, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  logic [255:0] dataT2, dataT3, dataT4, dataT5, dataT6;

  initial begin
    for (int i = 0; i < 32; i++) begin
      dataT2[8*i +: 8] = 8'(i);
      dataT3[8*i +: 8] = 8'(8'h80 + i);
    end
    for (int k = 0; k < 8; k++) dataT4[32*k +: 32] = 32'hA000_0000 + 32'(k);
    dataT5 = {8{32'hDEAD_BEEF}};
    dataT6 = {8{32'h1234_5678}};
    lastRead = '0;
    memInit = 1'b1;
    rst = 1'b0;
    idleInputs();

    #1;
    checkAllZero("reset");
    @(posedge clk); #1;
    memInit = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // T2: full write of bytes 0x00..0x1F to block 0x12 (words 0x90..0x97)
    applyStimulus(1'b1, 1'b0, 14'h0012, 32'hFFFF_FFFF, dataT2, '0, "T2");
    waitResp("T2");
    idleInputs();
    @(posedge clk); #1;
    checkOutput("T2_mem90", mem[17'h90], 32'h0302_0100);
    checkOutput("T2_mem97", mem[17'h97], 32'h1F1E_1D1C);

    // T3: upper half enabled only, block 0x20 (words 0x100..0x107)
    applyStimulus(1'b1, 1'b0, 14'h0020, 32'hFFFF_0000, dataT3, '0, "T3");
    waitResp("T3");
    idleInputs();
    @(posedge clk); #1;
    checkOutput("T3_mem100", mem[17'h100], 32'h0);
    checkOutput("T3_mem104", mem[17'h104], 32'h9392_9190);

    // T4: read preloaded block 0
    applyStimulus(1'b0, 1'b1, 14'h0000, 32'h0, '0, dataT4, "T4");
    waitResp("T4");
    idleInputs();
    @(posedge clk); #1;

    // T1: reset in the cycle beat 4 of a read is being issued
    rden = 1'b1; ipAddress = 14'h0005;
    for (int b = 0; b < 4; b++) expRd.push_back({14'h0005, 3'(b)});
    repeat (5) @(posedge clk);
    #1;
    checkOutput("T1_ramReBeat4", ramRe, 1);
    checkOutput("T1_ramAddrBeat4", ramAddr, 17'h2C);
    rst = 1'b0;
    idleInputs();
    #1;
    checkAllZero("T1");
    lastRead = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("T1_readDataAfter", readData, 0);
    checkOutput("T1_noPendingResp", 256'(expResp.size()), 0);

    // T5: simultaneous write and read, the write wins
    applyStimulus(1'b1, 1'b1, 14'h0030, 32'hFFFF_FFFF, dataT5, '0, "T5");
    waitResp("T5");
    idleInputs();
    @(posedge clk); #1;
    checkOutput("T5_mem180", mem[17'h180], 32'hDEAD_BEEF);

    // T6: read then write presented the cycle after resp_valid
    applyStimulus(1'b0, 1'b1, 14'h0012, 32'h0, '0, dataT2, "T6r");
    waitResp("T6r");
    applyStimulus(1'b1, 1'b0, 14'h0012, 32'hFFFF_FFFF, dataT6, '0, "T6w");
    waitResp("T6w");
    idleInputs();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("T6_mem90", mem[17'h90], 32'h1234_5678);
    checkOutput("T6_readDataHeld", readData, dataT2);

    checkOutput("end_expWrEmpty", 256'(expWr.size()), 0);
    checkOutput("end_expRdEmpty", 256'(expRd.size()), 0);
    checkOutput("end_expRespEmpty", 256'(expResp.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
